// File: rtl/lpddr_lp_state_tracker_if.sv
// lpddr_lp_state_tracker_if
//   Status bus from the LPDDR controller into the low-power state tracker.
//   master : the controller side. It drives stat_vld, op_mode, sr_state and sr_type.
//   slave  : the tracker side. It returns sr_type_q, the self-refresh cause latched at the
//            last SELF_REFRESH entry, for the debug shadow.
interface lpddr_lp_state_tracker_if;
  logic       stat_vld;
  logic [2:0] op_mode;
  logic [2:0] sr_state;
  logic [1:0] sr_type;
  logic [1:0] sr_type_q;

  modport master (output stat_vld, op_mode, sr_state, sr_type, input  sr_type_q);
  modport slave  (input  stat_vld, op_mode, sr_state, sr_type, output sr_type_q);
endinterface

// File: rtl/lpddr_lp_state_tracker.sv
// lpddr_lp_state_tracker
//   Shadows the controller's operating mode and self-refresh state. It flags illegal
//   transitions and encodings, and counts NORMAL->POWER_DOWN and NORMAL->SELF_REFRESH
//   entries.
//   Ports
//     clk, rst       : core clock, synchronous active-high reset
//     st             : status bus (slave modport); samples are accepted when stat_vld=1
//     mode_q         : last accepted op_mode
//     sr_state_q     : last accepted sr_state
//     err_pulse      : one-cycle pulse following a violating sample
//     err_code       : most recent violation code (1..5), held until the next violation
//     err_sticky     : set on any violation, cleared only by reset
//     sr_entry_cnt   : saturating count of legal NORMAL->SELF_REFRESH entries
//     pd_entry_cnt   : saturating count of legal NORMAL->POWER_DOWN entries
//     sr_res_cnt     : current self-refresh residency in cycles
//     sr_res_max     : longest completed self-refresh residency
//   Build option
//     LPDDR_LP_STATE_TRACKER_RESIDENCY_EN : when defined, sr_res_cnt and sr_res_max are live.
//     When it is not defined, both outputs are tied to 0. The minimum-residency check
//     stays active in both builds.
module lpddr_lp_state_tracker #(
  parameter int CNT_W      = 16,
  parameter int MIN_SR_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  lpddr_lp_state_tracker_if.slave    st,
  output logic [2:0]                 mode_q,
  output logic [2:0]                 sr_state_q,
  output logic                       err_pulse,
  output logic [2:0]                 err_code,
  output logic                       err_sticky,
  output logic [CNT_W-1:0]           sr_entry_cnt,
  output logic [CNT_W-1:0]           pd_entry_cnt,
  output logic [CNT_W-1:0]           sr_res_cnt,
  output logic [CNT_W-1:0]           sr_res_max
);
  localparam logic [2:0] M_INIT = 3'd0, M_NORM = 3'd1, M_PD = 3'd2, M_SR = 3'd3;
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_SR_CYC);

  logic [CNT_W-1:0] res_cnt, res_inc;
  logic       bad_enc, mode_ok, sr_ok, cons_bad, sr_exit, acc, sr_entry, pd_entry_ok, sr_entry_ok;
  logic [2:0] code;

  always_comb begin
    bad_enc = (st.op_mode > M_SR) || (st.sr_state > 3'd4);
    mode_ok = (st.op_mode == mode_q)
            || (mode_q == M_INIT && st.op_mode == M_NORM)
            || (mode_q == M_NORM && (st.op_mode == M_PD || st.op_mode == M_SR))
            || ((mode_q == M_PD || mode_q == M_SR) && st.op_mode == M_NORM);
    sr_ok   = (st.sr_state == sr_state_q)
            || (sr_state_q == 3'd0 && st.sr_state == 3'd1)
            || (sr_state_q == 3'd1 && (st.sr_state == 3'd2 || st.sr_state == 3'd0))
            || (sr_state_q == 3'd2 && (st.sr_state == 3'd3 || st.sr_state == 3'd4))
            || (sr_state_q == 3'd3 && st.sr_state == 3'd0)
            || (sr_state_q == 3'd4 && st.sr_state == 3'd2);
    cons_bad = (st.op_mode == M_SR) ? (st.sr_state == 3'd0) : (st.sr_state != 3'd0);
    sr_exit  = (mode_q == M_SR) && (st.op_mode != M_SR);
    // The completed residency includes the exit cycle itself, which is the value the
    // counter is about to take. A saturated counter stays saturated, so very long stays
    // still meet the minimum.
    res_inc  = (res_cnt == '1) ? res_cnt : res_cnt + 1'b1;

    code = 3'd0;
    if (st.stat_vld) begin
      if (bad_enc)                          code = 3'd1;
      else if (!mode_ok)                    code = 3'd2;
      else if (!sr_ok)                      code = 3'd3;
      else if (cons_bad)                    code = 3'd4;
      else if (sr_exit && (res_inc < MIN_C)) code = 3'd5;
    end

    // Codes 2..5 still update the shadow registers, so the tracker resynchronises to
    // the controller.
    acc         = st.stat_vld && (code != 3'd1);
    sr_entry    = acc && (mode_q != M_SR) && (st.op_mode == M_SR);
    sr_entry_ok = st.stat_vld && (code == 3'd0) && (mode_q == M_NORM) && (st.op_mode == M_SR);
    pd_entry_ok = st.stat_vld && (code == 3'd0) && (mode_q == M_NORM) && (st.op_mode == M_PD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= M_INIT;
      sr_state_q   <= 3'd0;
      err_pulse    <= 1'b0;
      err_code     <= 3'd0;
      err_sticky   <= 1'b0;
      sr_entry_cnt <= '0;
      pd_entry_cnt <= '0;
      res_cnt      <= '0;
      st.sr_type_q <= 2'd0;
    end else begin
      err_pulse <= (code != 3'd0);
      if (code != 3'd0) begin
        err_code   <= code;
        err_sticky <= 1'b1;
      end
      if (acc) begin
        mode_q     <= st.op_mode;
        sr_state_q <= st.sr_state;
      end
      if (sr_entry_ok && sr_entry_cnt != '1) sr_entry_cnt <= sr_entry_cnt + 1'b1;
      if (pd_entry_ok && pd_entry_cnt != '1) pd_entry_cnt <= pd_entry_cnt + 1'b1;
      // The residency counter runs on every clock while the tracked mode is
      // SELF_REFRESH, not only on cycles with an accepted sample.
      if (sr_entry) begin
        res_cnt      <= '0;
        st.sr_type_q <= st.sr_type;
      end else if (mode_q == M_SR) begin
        res_cnt <= res_inc;
      end
    end
  end

`ifdef LPDDR_LP_STATE_TRACKER_RESIDENCY_EN
  logic [CNT_W-1:0] res_max;
  always_ff @(posedge clk) begin
    if (rst)                                        res_max <= '0;
    else if (acc && sr_exit && (res_inc > res_max)) res_max <= res_inc;
  end
  assign sr_res_cnt = res_cnt;
  assign sr_res_max = res_max;
`else
  assign sr_res_cnt = '0;
  assign sr_res_max = '0;
`endif
endmodule
